quartsine_phase_search: RTL and testbench
=========================================

// Module: quartsine_phase_search
// PURPOSE
//  Inverse of the quarter-wave sine lookup: converts an 11-bit offset-binary sine sample
//  (midscale 1024) back to the 8-bit phase that produces it.
//  Runs a 6-step successive-approximation search over the 64-entry quarter-sine block RAM.
//  Drives the same RAM port signals (ena/wea/addr/din) and consumes its 1-cycle-latency douta.
//  Used for phase recovery/loopback checks against the sine generator path.
// PARAMETERS
//  DW     11  sample / RAM data width (offset binary, midscale 2**(DW-1))
//  AW     6   quarter-table address width (2**AW entries)
//  PW     8   phase width (= AW+2: sign bit, slope bit, table index)
// PORTS
//  clka       in   1   clock, all logic on rising edge
//  rst        in   1   asynchronous, active-high reset
//  start      in   1   request; sampled only in IDLE
//  sample     in   11  offset-binary sine sample, captured on accepted start
//  falling    in   1   0 = return rising-slope phase, 1 = falling-slope phase (same half-cycle)
//  busy       out  1   high while a search is in progress (state != IDLE)
//  done       out  1   one-cycle pulse, phase valid
//  phase      out  8   recovered phase, held until next accepted start
//  rom_ena    out  1   RAM enable, high only in RD
//  rom_wea    out  1   constant 0
//  rom_addr   out  6   RAM address
//  rom_dina   out  11  constant 0
//  rom_dout   in   11  RAM read data, valid the cycle after rom_addr/rom_ena are presented
// BEHAVIOUR
//  Reset: state=IDLE, busy=0, done=0, phase=0, rom_ena=0, rom_addr=0, internal k=0, bit=5.
//  Capture on start in IDLE (edge 0):
//   pos <= (sample >= 1024)
//   mag <= pos ? sample : 2048 - sample   (12-bit arithmetic, range 1024..2048)
//   slope <= falling, k <= 0, bit <= 5; go to RD.
//  RD:   rom_ena=1, rom_addr = k | (1<<bit); go to CMP.
//  CMP:  rom_dout = T[k|(1<<bit)]; if zero-extended T <= mag then k <= k|(1<<bit).
//        If bit==0 go to DONE, else bit <= bit-1 and go to RD.
//  DONE: phase <= {~pos, slope, slope ? ~k : k}; done=1 for this cycle only; go to IDLE.
//  Result: k = largest index with T[k] <= mag (table monotonic non-decreasing).
//   - mag < T[0]: k = 0 (clamp).
//   - mag >= T[63] (incl. 2048): k = 63.
//  Timing: RD cycles 1,3,..,11; CMP cycles 2,..,12; done high in cycle 13 after the start edge.
//   Next start accepted in cycle 14. Throughput: one conversion per 14 cycles.
//  busy: high from cycle 1 through cycle 13 inclusive.
//  start while busy or in DONE: ignored, no queuing. Captured sample/falling are unaffected by input changes.
//  rst mid-search: immediate abort; all outputs take reset values, no done pulse, previous phase lost (0).
//  rom_addr holds its last value outside RD; the RAM is never written.
// TESTING (bench RAM model: 1-cycle latency, T[k] = 1024 + 16*k)
//  sample=1184, falling=0 -> done 13 cycles after start, phase=8'h0A; 6 rom_ena pulses.
//  sample=1184, falling=1 -> phase=8'h75 ({0,1,~6'd10}).
//  sample=864 (mag 1184), falling=0 -> phase=8'h8A.
//  sample=2047 -> phase=8'h3F.
//  sample=1023 (mag 1025) -> phase=8'h80.
//  sample=0 (mag 2048) -> phase=8'hBF.
//  Start pulse at cycle 5 of a search -> ignored, single done; rst at cycle 7 -> busy=0, done never pulses, phase=0.
//  Alternate table with T[0]=1030, sample=1024 -> clamp phase=8'h00.
//  Back-to-back: start held high -> conversions complete every 14 cycles.

Source files
------------

// File: rtl/quartsine_phase_search.sv
// Quarter-wave sine inverse: recovers the 8-bit phase of an offset-binary sine
// sample with a 6-step successive-approximation search over the quarter-sine RAM.
module quartsine_phase_search #(
    parameter int DW = 11,
    parameter int AW = 6,
    parameter int PW = 8
) (
    input  logic          clka,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] sample,
    input  logic          falling,
    output logic          busy,
    output logic          done,
    output logic [PW-1:0] phase,
    output logic          rom_ena,
    output logic          rom_wea,
    output logic [AW-1:0] rom_addr,
    output logic [DW-1:0] rom_dina,
    input  logic [DW-1:0] rom_dout
);

    localparam int BW = $clog2(AW);
    localparam logic [BW-1:0] TOP_BIT = BW'(AW - 1);
    localparam logic [DW:0]   FULL    = (DW + 1)'(1) << DW;

    // Handshake: start is sampled only in IDLE; done is a one-cycle pulse with
    // phase valid in the same cycle, and phase holds until the next accepted start.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        CMP  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          pos;
    logic          slope;
    logic [DW:0]   mag;
    logic [AW-1:0] k;
    logic [BW-1:0] bit_idx;
    logic [AW-1:0] probe;
    logic [AW-1:0] k_new;
    logic          take;

    // Trial bit and the candidate index after this comparison
    always_comb begin
        probe = AW'(1) << bit_idx;
        take  = ({1'b0, rom_dout} <= mag);
        k_new = take ? (k | probe) : k;
    end

    // State register; reset aborts any search in progress
    always_ff @(posedge clka or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and decoded outputs
    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        done      = (state == DONE);
        rom_ena   = (state == RD);
        rom_wea   = 1'b0;
        rom_dina  = '0;
        case (state)
            IDLE: if (start) state_nxt = RD;
            RD:   state_nxt = CMP;
            CMP:  state_nxt = (bit_idx == '0) ? DONE : RD;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Search datapath: capture, successive approximation, result formatting.
    // rom_addr is loaded ahead of each RD so it holds its last value elsewhere.
    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            pos      <= 1'b0;
            slope    <= 1'b0;
            mag      <= '0;
            k        <= '0;
            bit_idx  <= TOP_BIT;
            rom_addr <= '0;
            phase    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        pos      <= sample[DW-1];
                        mag      <= sample[DW-1] ? {1'b0, sample} : FULL - {1'b0, sample};
                        slope    <= falling;
                        k        <= '0;
                        bit_idx  <= TOP_BIT;
                        rom_addr <= AW'(1) << TOP_BIT;
                    end
                end
                CMP: begin
                    k <= k_new;
                    if (bit_idx != '0) begin
                        bit_idx  <= bit_idx - 1'b1;
                        rom_addr <= k_new | (probe >> 1);
                    end else begin
                        // Negative half-cycle sets the sign bit; falling slope mirrors the index
                        phase <= {~pos, slope, slope ? ~k_new : k_new};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_quartsine_phase_search.sv
// Directed bench for quartsine_phase_search with a 1-cycle-latency linear RAM model.
module tb_quartsine_phase_search;

    logic        clka = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [10:0] sample = '0;
    logic        falling = 1'b0;
    logic        busy;
    logic        done;
    logic [7:0]  phase;
    logic        rom_ena;
    logic        rom_wea;
    logic [5:0]  rom_addr;
    logic [10:0] rom_dina;
    logic [10:0] rom_dout = '0;
    logic        table_sel = 1'b0;

    int checks = 0;
    int failures = 0;

    quartsine_phase_search dut (
        .clka(clka), .rst(rst), .start(start), .sample(sample), .falling(falling),
        .busy(busy), .done(done), .phase(phase), .rom_ena(rom_ena), .rom_wea(rom_wea),
        .rom_addr(rom_addr), .rom_dina(rom_dina), .rom_dout(rom_dout)
    );

    // Clock
    always #5 clka = ~clka;

    // RAM model: T[k] = 1024 + 16k (alternate table: 1030 + 16k)
    always @(posedge clka) begin
        if (rom_ena)
            rom_dout <= table_sel ? 11'(1030 + 16 * rom_addr) : 11'(1024 + 16 * rom_addr);
    end

    task automatic tick;
        @(posedge clka);
        #1;
    endtask

    // Issue one start and return latency (cycles after start edge to done) and ena count
    task automatic run_conv(input logic [10:0] s, input logic f, output int lat, output int enas,
                            output logic busy1, output logic [5:0] addr1);
        sample = s;
        falling = f;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 1;
        busy1 = busy;
        addr1 = rom_addr;
        enas = int'(rom_ena);
        while (!done && lat < 40) begin
            tick();
            lat++;
            enas += int'(rom_ena);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || phase !== 8'h00 || rom_ena !== 1'b0 || rom_addr !== 6'd0) begin
            failures++;
            $display("FAIL reset_outputs: busy=%b done=%b phase=%h ena=%b addr=%0d want 0 0 00 0 0",
                     busy, done, phase, rom_ena, rom_addr);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (rom_wea !== 1'b0 || rom_dina !== 11'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: wea=%b dina=%0d busy=%b want 0 0 0", rom_wea, rom_dina, busy);
        end
    endtask

    task automatic test_basic;
        int lat, enas;
        logic b1;
        logic [5:0] a1;
        run_conv(11'd1184, 1'b0, lat, enas, b1, a1);
        checks++;
        if (lat !== 13) begin
            failures++;
            $display("FAIL basic_latency: got %0d want 13", lat);
        end
        checks++;
        if (enas !== 6) begin
            failures++;
            $display("FAIL basic_ena_pulses: got %0d want 6", enas);
        end
        checks++;
        if (b1 !== 1'b1 || a1 !== 6'd32) begin
            failures++;
            $display("FAIL basic_first_read: busy=%b addr=%0d want 1 32", b1, a1);
        end
        checks++;
        if (phase !== 8'h0A) begin
            failures++;
            $display("FAIL basic_phase: got %h want 0a", phase);
        end
        // Result and last address hold after the done pulse
        repeat (5) tick();
        checks++;
        if (phase !== 8'h0A || done !== 1'b0 || busy !== 1'b0 || rom_addr !== 6'd11) begin
            failures++;
            $display("FAIL basic_hold: phase=%h done=%b busy=%b addr=%0d want 0a 0 0 11",
                     phase, done, busy, rom_addr);
        end
    endtask

    task automatic test_vectors;
        logic [10:0] s_v[5] = '{11'd1184, 11'd864, 11'd2047, 11'd1023, 11'd0};
        logic        f_v[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [7:0]  p_v[5] = '{8'h75, 8'h8A, 8'h3F, 8'h80, 8'hBF};
        int lat, enas;
        logic b1;
        logic [5:0] a1;
        for (int i = 0; i < 5; i++) begin
            run_conv(s_v[i], f_v[i], lat, enas, b1, a1);
            checks++;
            if (phase !== p_v[i] || lat !== 13) begin
                failures++;
                $display("FAIL vector_%0d: sample=%0d phase=%h lat=%0d want %h 13",
                         i, s_v[i], phase, lat, p_v[i]);
            end
            tick();
        end
    endtask

    task automatic test_clamp;
        int lat, enas;
        logic b1;
        logic [5:0] a1;
        table_sel = 1'b1;
        run_conv(11'd1024, 1'b0, lat, enas, b1, a1);
        checks++;
        if (phase !== 8'h00 || lat !== 13) begin
            failures++;
            $display("FAIL clamp_low: phase=%h lat=%0d want 00 13", phase, lat);
        end
        tick();
        table_sel = 1'b0;
    endtask

    task automatic test_ignore_start;
        int lat;
        int extra;
        sample = 11'd1184;
        falling = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 1;
        while (lat < 5) begin
            tick();
            lat++;
        end
        // Mid-search start pulse with different inputs must be ignored
        start = 1'b1;
        sample = 11'd0;
        falling = 1'b1;
        tick();
        lat++;
        start = 1'b0;
        while (!done && lat < 40) begin
            tick();
            lat++;
        end
        checks++;
        if (lat !== 13 || phase !== 8'h0A) begin
            failures++;
            $display("FAIL ignore_start: lat=%0d phase=%h want 13 0a", lat, phase);
        end
        extra = 0;
        repeat (20) begin
            tick();
            extra += int'(done);
        end
        checks++;
        if (extra !== 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL ignore_start_single_done: extra=%0d busy=%b want 0 0", extra, busy);
        end
    endtask

    task automatic test_rst_abort;
        int lat;
        int seen;
        checks++;
        if (phase !== 8'h0A) begin
            failures++;
            $display("FAIL abort_prior_phase: got %h want 0a", phase);
        end
        sample = 11'd2047;
        falling = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 1;
        while (lat < 7) begin
            tick();
            lat++;
        end
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || phase !== 8'h00 || rom_ena !== 1'b0 || rom_addr !== 6'd0) begin
            failures++;
            $display("FAIL abort_reset: busy=%b done=%b phase=%h ena=%b addr=%0d want 0 0 00 0 0",
                     busy, done, phase, rom_ena, rom_addr);
        end
        tick();
        rst = 1'b0;
        seen = 0;
        repeat (20) begin
            tick();
            seen += int'(done) + int'(busy);
        end
        checks++;
        if (seen !== 0 || phase !== 8'h00) begin
            failures++;
            $display("FAIL abort_no_done: activity=%0d phase=%h want 0 00", seen, phase);
        end
    endtask

    task automatic test_back_to_back;
        int n;
        int first_done;
        int second_done;
        first_done = 0;
        second_done = 0;
        sample = 11'd864;
        falling = 1'b0;
        start = 1'b1;
        tick();
        n = 1;
        while (second_done == 0 && n < 60) begin
            if (done) begin
                if (first_done == 0) first_done = n;
                else second_done = n;
            end
            if (second_done == 0) begin
                tick();
                n++;
            end
        end
        start = 1'b0;
        checks++;
        if (first_done !== 13 || second_done !== 27) begin
            failures++;
            $display("FAIL back_to_back_timing: dones at %0d,%0d want 13,27", first_done, second_done);
        end
        checks++;
        if (phase !== 8'h8A) begin
            failures++;
            $display("FAIL back_to_back_phase: got %h want 8a", phase);
        end
        repeat (3) tick();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL back_to_back_idle: busy=%b want 0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_vectors();
        test_clamp();
        test_ignore_start();
        test_rst_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
